dmem_lsu: RTL

//  MEM-stage load/store unit: drives single-outstanding data-memory bus transactions and stalls the pipeline until each completes.

---
 rtl/dmem_lsu_pkg.sv | 32 +++
 rtl/dmem_lsu_align.sv | 60 ++++++
 rtl/dmem_lsu.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit.
//   mem_size_t  : access size encoding carried from decode (11 behaves as word)
//   lsu_state_t : LSU bus-transaction FSM states
//   lsu_req_t   : request captured in IDLE and replayed onto the bus
package dmem_lsu_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned BE_W = XLEN / 8;

   typedef enum logic [1:0] {
      MEM_B = 2'b00,
      MEM_H = 2'b01,
      MEM_W = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      RESP = 2'b10,
      DONE = 2'b11
   } lsu_state_t;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic            we;
      logic [1:0]      size;
      logic            uns;
      logic [BE_W-1:0] be;
      logic [XLEN-1:0] wdata;
   } lsu_req_t;

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic for the LSU.
//   i_size, i_addr_lo, i_unsigned : access descriptor
//   i_wdata      : low-aligned store data      -> o_wdata : lane-replicated store data
//   i_rdata      : raw bus read word           -> o_load_data : extracted, extended load
//   o_be         : byte enables
//   o_misaligned : half on odd address or word not on a 4-byte boundary
module dmem_lsu_align
   import dmem_lsu_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic        i_unsigned,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic        o_misaligned,
   output logic [31:0] o_load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane selection from the read word
   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   // Size-dependent enables, replication, alignment check and extension
   always_comb begin
      o_be         = 4'b1111;
      o_wdata      = i_wdata;
      o_misaligned = 1'b0;
      o_load_data  = i_rdata;
      case (mem_size_t'(i_size))
         MEM_B: begin
            o_be        = 4'b0001 << i_addr_lo;
            o_wdata     = {4{i_wdata[7:0]}};
            o_load_data = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         MEM_H: begin
            o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata      = {2{i_wdata[15:0]}};
            o_misaligned = i_addr_lo[0];
            o_load_data  = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
         end
         default: begin
            o_misaligned = (i_addr_lo != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: one outstanding data-bus transaction at a time,
// stalling the pipeline until it completes, and producing the extended load word.
//   clk, rst_n                      : clock / async active-low reset
//   req_*_i                         : MEM-stage request (held stable while stall_o)
//   stall_o, done_o, load_data_o    : pipeline control and load result
//   misalign_o, bus_err_o           : single-cycle exception pulses
//   bus_*_o / bus_*_i               : request/grant + response data bus
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        stall_o,
   output logic        done_o,
   output logic [31:0] load_data_o,
   output logic        misalign_o,
   output logic        bus_err_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_err_i
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   lsu_state_t       r_state;
   lsu_state_t       w_next_state;
   lsu_req_t         r_req;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   logic [31:0]      r_load_data;

   logic             w_idle;
   logic [1:0]       w_al_size;
   logic [1:0]       w_al_addr_lo;
   logic             w_al_uns;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic             w_misaligned;
   logic [31:0]      w_load_ext;
   logic             w_accept;
   logic             w_timeout;

   assign w_idle = (r_state == IDLE);

   // In IDLE the lane unit judges the incoming request; afterwards it
   // extracts the load using the captured descriptor.
   assign w_al_size    = w_idle ? req_size_i      : r_req.size;
   assign w_al_addr_lo = w_idle ? req_addr_i[1:0] : r_req.addr[1:0];
   assign w_al_uns     = w_idle ? req_unsigned_i  : r_req.uns;

   dmem_lsu_align u_align (
      .i_size       (w_al_size),
      .i_addr_lo    (w_al_addr_lo),
      .i_unsigned   (w_al_uns),
      .i_wdata      (req_wdata_i),
      .i_rdata      (bus_rdata_i),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_misaligned (w_misaligned),
      .o_load_data  (w_load_ext)
   );

   assign w_accept  = w_idle & req_valid_i & ~w_misaligned;
   assign w_timeout = (r_cnt == CNT_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state logic; rvalid in REQ is ignored even alongside gnt
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next_state = REQ;
         REQ:     if (bus_gnt_i) w_next_state = RESP;
         RESP:    if (bus_rvalid_i || w_timeout) w_next_state = DONE;
         default: w_next_state = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      stall_o     = w_accept | (r_state == REQ) | (r_state == RESP);
      done_o      = (r_state == DONE);
      bus_err_o   = (r_state == DONE) & r_err;
      misalign_o  = w_idle & req_valid_i & w_misaligned;
      bus_req_o   = (r_state == REQ);
      bus_we_o    = r_req.we;
      bus_addr_o  = {r_req.addr[31:2], 2'b00};
      bus_be_o    = r_req.be;
      bus_wdata_o = r_req.wdata;
   end

   assign load_data_o = r_load_data;

   // Request capture, response timeout, error flag and load result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req       <= '0;
         r_cnt       <= '0;
         r_err       <= 1'b0;
         r_load_data <= '0;
      end else begin
         if (w_accept) begin
            r_req <= '{addr:  req_addr_i,
                       we:    req_we_i,
                       size:  req_size_i,
                       uns:   req_unsigned_i,
                       be:    w_be,
                       wdata: w_wdata};
         end
         if ((r_state == REQ) && bus_gnt_i) begin
            r_cnt <= '0;
         end else if ((r_state == RESP) && !bus_rvalid_i && !w_timeout) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (r_state == RESP) begin
            if (bus_rvalid_i) r_err <= bus_err_i;
            else if (w_timeout) r_err <= 1'b1;
         end
         // Stores and errored loads keep the previous result
         if ((r_state == RESP) && bus_rvalid_i && !bus_err_i && !r_req.we) begin
            r_load_data <= w_load_ext;
         end
      end
   end

endmodule
